// File: rtl/pixel_stream_unpacker.sv
// pixel_stream_unpacker: buffers 16-bit readout words (two pixels each) in a
// small FIFO and serializes them as an 8-bit valid/ready pixel stream.
//
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   pix_word[15:0]      readout word, low byte is the first pixel
//   pix_word_valid      one-cycle pulse per word
//   frame_start         next accepted word starts a new frame
//   out_data[7:0]       pixel code (0 while out_valid is low)
//   out_valid/out_ready stream handshake
//   out_sof, out_eol    first pixel of frame / last pixel of line
//   fifo_level          words currently stored
//   overflow            sticky drop flag, cleared by clear_overflow
//   frame_checksum      sum of pixels since the last start-of-frame pixel
//
// Optional build macro: FRAME_CHECKSUM_EN enables frame_checksum; when
// undefined the output is tied to zero and no adder exists.

module pixel_stream_unpacker #(
    parameter int DEPTH           = 8,
    parameter int PIXELS_PER_LINE = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              pix_word,
    input  logic                     pix_word_valid,
    input  logic                     frame_start,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow,
    input  logic                     clear_overflow,
    output logic [15:0]              frame_checksum
);

    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int LCW = $clog2(PIXELS_PER_LINE);

    localparam logic [LW-1:0]  DEPTH_L = LW'(DEPTH);
    localparam logic [LCW-1:0] LAST    = LCW'(PIXELS_PER_LINE - 1);

    // entry = {sof_tag, pix_word}
    logic [16:0]    mem_q [DEPTH];
    logic [16:0]    mem_d [DEPTH];

    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]  level_q, level_d;
    logic           sel_q, sel_d;
    logic           pending_sof_q, pending_sof_d;
    logic [LCW-1:0] lcnt_q, lcnt_d;
    logic           overflow_q, overflow_d;

    logic [16:0]    head;
    logic           accept;
    logic           pop;
    logic           wr_en;
    logic           drop;

    assign head = mem_q[rd_ptr_q];

    // Stream outputs are presented straight from the head entry so a word
    // written into an empty FIFO is visible on the very next cycle.
    always_comb begin
        out_valid = (level_q != '0);
        out_data  = 8'h00;
        if (out_valid) begin
            out_data = sel_q ? head[15:8] : head[7:0];
        end
        out_sof = out_valid & head[16] & ~sel_q;
        out_eol = out_valid & (lcnt_q == LAST);
    end

    assign accept = out_valid & out_ready;
    assign pop    = accept & sel_q;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign wr_en  = pix_word_valid & ((level_q < DEPTH_L) | pop);
    assign drop   = pix_word_valid & ~wr_en;

    assign fifo_level = level_q;
    assign overflow   = overflow_q;

    always_comb begin
        mem_d         = mem_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q;
        sel_d         = sel_q;
        pending_sof_d = pending_sof_q;
        lcnt_d        = lcnt_q;
        overflow_d    = overflow_q;

        if (wr_en) begin
            mem_d[wr_ptr_q] = {pending_sof_q | frame_start, pix_word};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end

        // A write consumes the pending tag; a dropped word leaves it alone.
        if (wr_en) begin
            pending_sof_d = 1'b0;
        end else if (frame_start) begin
            pending_sof_d = 1'b1;
        end

        if (accept) begin
            sel_d = ~sel_q;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_en, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase

        // A start-of-frame pixel is pixel 0 of its line, so the next is 1.
        if (accept) begin
            if (out_sof) begin
                lcnt_d = LCW'(1);
            end else if (lcnt_q == LAST) begin
                lcnt_d = '0;
            end else begin
                lcnt_d = lcnt_q + LCW'(1);
            end
        end

        // Set wins over clear when both happen together.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            sel_q         <= 1'b0;
            pending_sof_q <= 1'b0;
            lcnt_q        <= '0;
            overflow_q    <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            sel_q         <= sel_d;
            pending_sof_q <= pending_sof_d;
            lcnt_q        <= lcnt_d;
            overflow_q    <= overflow_d;
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (accept) begin
            if (out_sof) begin
                csum_d = {8'h00, out_data};
            end else begin
                csum_d = csum_q + {8'h00, out_data};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign frame_checksum = csum_q;
`else
    assign frame_checksum = 16'h0000;
`endif

endmodule
